// File: rtl/cfg_frame_rx.sv
// Serial configuration frame receiver: hunts for a sync word, captures the
// payload into a shadow register and commits it to CFG_OUT on even parity.
module cfg_frame_rx #(
  parameter int                PAYLOAD_W    = 11,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
  input  logic                 CLK_SR,
  input  logic                 RST,
  input  logic                 SER_IN,
  output logic [PAYLOAD_W-1:0] CFG_OUT,
  output logic                 CFG_VALID,
  output logic                 CFG_UPD,
  output logic                 FRAME_ERR,
  output logic                 BUSY,
  output logic [3:0]           ERR_CNT
);

  localparam int IDX_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_PARITY
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_W-1:0]      window_q, window_d;
  logic [SYNC_W-1:0]      window_next;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PAYLOAD_W-1:0]   shadow_q, shadow_d;
  logic [PAYLOAD_W-1:0]   cfg_q, cfg_d;
  logic                   valid_q, valid_d;
  logic                   upd_q, upd_d;
  logic                   ferr_q, ferr_d;
  logic [3:0]             errcnt_q, errcnt_d;
  logic                   par_bad;

  always_ff @(posedge CLK_SR or posedge RST) begin
    if (RST) begin
      state_q  <= S_HUNT;
      window_q <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
      ferr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      ferr_q   <= ferr_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    valid_d     = valid_q;
    upd_d       = 1'b0;
    ferr_d      = 1'b0;
    errcnt_d    = errcnt_q;
    window_next = {window_q[SYNC_W-2:0], SER_IN};
    par_bad     = (^shadow_q) ^ SER_IN;

    case (state_q)
      S_HUNT: begin
        window_d = window_next;
        if (window_next == SYNC_PATTERN) begin
          state_d  = S_PAYLOAD;
          idx_d    = '0;
          window_d = '0;
        end
      end
      S_PAYLOAD: begin
        shadow_d[idx_q] = SER_IN;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IDX_W'(PAYLOAD_W - 1)) state_d = S_PARITY;
      end
      S_PARITY: begin
        if (!par_bad) begin
          cfg_d   = shadow_q;
          valid_d = 1'b1;
          upd_d   = 1'b1;
        end else begin
          ferr_d = 1'b1;
          if (errcnt_q != 4'hF) errcnt_d = errcnt_q + 4'd1;
        end
        // Window was cleared on the sync match, so the next hunt starts from zero.
        state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  assign CFG_OUT   = cfg_q;
  assign CFG_VALID = valid_q;
  assign CFG_UPD   = upd_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != S_HUNT);
  assign ERR_CNT   = errcnt_q;

endmodule

// File: tb/tb_cfg_frame_rx.sv
// Bench for cfg_frame_rx: directed frames plus random bit streams, every edge
// compared against a stream-parsing reference model.
module tb_cfg_frame_rx;

  logic        CLK_SR = 1'b0;
  logic        RST    = 1'b1;
  logic        SER_IN = 1'b0;
  logic [10:0] CFG_OUT;
  logic        CFG_VALID, CFG_UPD, FRAME_ERR, BUSY;
  logic [3:0]  ERR_CNT;

  cfg_frame_rx #(.PAYLOAD_W(11), .SYNC_W(4), .SYNC_PATTERN(4'b1011)) dut (
    .CLK_SR(CLK_SR), .RST(RST), .SER_IN(SER_IN), .CFG_OUT(CFG_OUT),
    .CFG_VALID(CFG_VALID), .CFG_UPD(CFG_UPD), .FRAME_ERR(FRAME_ERR),
    .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK_SR = ~CLK_SR;

  int total = 0;
  int bad   = 0;

  // Reference model: the last four bits seen since reset/frame end, and the
  // number of frame bits collected once the sync word has been seen.
  bit m_in;
  int m_n, m_hist, m_pay, m_cfg, m_valid, m_upd, m_ferr, m_err;

  int cyc, busy_cnt, upd_cnt, ferr_cnt, last_upd_cyc, upd_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_n = 0; m_hist = 0; m_pay = 0;
    m_cfg = 0; m_valid = 0; m_upd = 0; m_ferr = 0; m_err = 0;
  endtask

  task automatic model_step(input bit b);
    m_upd  = 0;
    m_ferr = 0;
    if (!m_in) begin
      m_hist = ((m_hist << 1) | int'(b)) & 15;
      if (m_hist == 11) begin
        m_in = 1; m_n = 0; m_hist = 0; m_pay = 0;
      end
    end else if (m_n < 11) begin
      m_pay = m_pay | (int'(b) << m_n);
      m_n++;
    end else begin
      if ((($countones(m_pay) + int'(b)) % 2) == 0) begin
        m_cfg = m_pay; m_valid = 1; m_upd = 1;
      end else begin
        m_ferr = 1;
        if (m_err < 15) m_err++;
      end
      m_in = 0; m_hist = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cfg"},   32'(CFG_OUT),   32'(m_cfg));
    check({tag, ".valid"}, 32'(CFG_VALID), 32'(m_valid));
    check({tag, ".upd"},   32'(CFG_UPD),   32'(m_upd));
    check({tag, ".ferr"},  32'(FRAME_ERR), 32'(m_ferr));
    check({tag, ".busy"},  32'(BUSY),      32'(m_in));
    check({tag, ".errcnt"},32'(ERR_CNT),   32'(m_err));
  endtask

  task automatic send_bit(input bit b);
    SER_IN = b;
    @(posedge CLK_SR);
    model_step(b);
    #1;
    check_all("edge");
    cyc++;
    if (BUSY) busy_cnt++;
    if (FRAME_ERR) ferr_cnt++;
    if (CFG_UPD) begin
      upd_cnt++;
      upd_gap      = cyc - last_upd_cyc;
      last_upd_cyc = cyc;
    end
  endtask

  task automatic send_sync();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
  endtask

  task automatic send_body(input logic [10:0] pay, input bit par);
    for (int i = 0; i < 11; i++) send_bit(pay[i]);
    send_bit(par);
  endtask

  task automatic send_frame(input logic [10:0] pay, input bit par);
    send_sync();
    send_body(pay, par);
  endtask

  task automatic clear_counts();
    busy_cnt = 0; upd_cnt = 0; ferr_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK_SR);
    RST = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge CLK_SR);
    @(negedge CLK_SR);
    RST = 1'b0;
  endtask

  initial begin
    logic [10:0] rp;
    bit          rb;
    cyc = 0; last_upd_cyc = 0; upd_gap = 0;
    clear_counts();
    model_reset();

    // Frame 5A5: one update at the 16th edge, 12 busy cycles.
    do_reset();
    clear_counts();
    cyc = 0;
    send_frame(11'h5A5, 1'b0);
    check("f1.cfg",   32'(CFG_OUT), 32'h5A5);
    check("f1.valid", 32'(CFG_VALID), 32'd1);
    check("f1.upd_edge", 32'(last_upd_cyc), 32'd16);
    check("f1.busy_cycles", 32'(busy_cnt), 32'd12);
    check("f1.upd_count", 32'(upd_cnt), 32'd1);

    // Bad parity keeps the old config; corrected frame then updates.
    clear_counts();
    send_frame(11'h001, 1'b0);
    check("f2.ferr_count", 32'(ferr_cnt), 32'd1);
    check("f2.errcnt", 32'(ERR_CNT), 32'd1);
    check("f2.cfg_kept", 32'(CFG_OUT), 32'h5A5);
    send_frame(11'h001, 1'b1);
    check("f3.cfg", 32'(CFG_OUT), 32'h001);

    // Leading noise ending in the sync word; payload holds 1011 LSB-first.
    clear_counts();
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_body(11'h00D, 1'b1);
    check("noise.cfg", 32'(CFG_OUT), 32'h00D);
    check("noise.upd_count", 32'(upd_cnt), 32'd1);
    check("noise.ferr_count", 32'(ferr_cnt), 32'd0);

    // Back-to-back good frames.
    clear_counts();
    send_frame(11'h7FF, 1'b1);
    send_frame(11'h000, 1'b0);
    check("b2b.upd_count", 32'(upd_cnt), 32'd2);
    check("b2b.gap", 32'(upd_gap), 32'd16);
    check("b2b.cfg", 32'(CFG_OUT), 32'h000);

    // Reset in the middle of a payload, then a good frame.
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(i[0]);
    do_reset();
    check("midrst.cfg0", 32'(CFG_OUT), 32'h0);
    check("midrst.busy0", 32'(BUSY), 32'd0);
    send_frame(11'h2AA, 1'b1);
    check("midrst.cfg", 32'(CFG_OUT), 32'h2AA);
    check("midrst.errcnt", 32'(ERR_CNT), 32'd0);

    // Saturation of the error counter.
    do_reset();
    clear_counts();
    for (int f = 0; f < 17; f++) begin
      rp = 11'($urandom);
      send_frame(rp, ~(^rp));
    end
    check("sat.errcnt", 32'(ERR_CNT), 32'd15);
    check("sat.ferr_count", 32'(ferr_cnt), 32'd17);
    check("sat.valid", 32'(CFG_VALID), 32'd0);

    // Random frames with random parity, then a free-running random stream.
    do_reset();
    for (int f = 0; f < 20; f++) begin
      rp = 11'($urandom);
      rb = 1'($urandom);
      send_frame(rp, rb);
    end
    for (int i = 0; i < 400; i++) begin
      rb = 1'($urandom);
      send_bit(rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
